bcd_serial_subtractor: RTL and testbench
========================================

Name: bcd_serial_subtractor

Overview:
Digit-serial multi-digit packed-BCD subtractor: diff = a - b - bin, one BCD digit per clock, least-significant digit first, using ten's-complement borrow.
It is the subtraction counterpart of the team's combinational single-digit BCD adder. It is used by the BCD arithmetic datapath wherever decrementing or difference operations on decimal operands are needed.
It uses a start/busy/done handshake so a sequencer can chain operations.

Parameters:
DIGITS, 4, number of BCD digits per operand (must be at least 1); operand width is 4*DIGITS.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a new operation; sampled only when not busy
a  input  4*DIGITS  minuend, packed BCD, digit 0 at bits [3:0]
b  input  4*DIGITS  subtrahend, packed BCD
bin  input  1  borrow-in to digit 0
busy  output  1  high while digits are being processed
done  output  1  one-cycle pulse, result valid
diff  output  4*DIGITS  packed BCD difference, held until the next accepted start
bout  output  1  borrow-out of the most-significant digit; held with diff
err  output  1  high if any digit of a or b was greater than 9 in the accepted operation; held with diff

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, diff=0, bout=0, err=0, state IDLE, digit index 0.
- Reset has priority over every other event. Asserting rst mid-operation aborts the operation, and the next edge returns to IDLE with all outputs cleared.
- States:
  - IDLE: waiting for start.
  - CALC: processing digits.
  - DONE: done=1 for exactly one cycle.
- Transitions:
  - IDLE or DONE with start=1: latch a, b and bin into internal registers. Clear diff. Set the err flag from a check of all latched digits. Set index=0 and go to CALC with busy=1.
  - DONE with start=0: go to IDLE.
  - CALC: on each edge, process digit[index] and write it into diff[index].
  - CALC, index==DIGITS-1: go to DONE, busy=0, done=1, and write bout from the final borrow. Otherwise increment index.
- Start while in CALC is ignored, with no queuing. Inputs a, b and bin may change freely after the start edge.
- Latency: with the start edge counted as edge 0, done is high in the cycle after edge DIGITS. Busy is high for exactly DIGITS cycles. Back-to-back throughput is one operation per DIGITS+1 cycles, with start accepted in the DONE cycle.
- Per-digit arithmetic, with the signed 6-bit t = a_d - b_d - borrow:
  - If t<0: out digit = (t+10)[3:0], borrow=1.
  - Else: out digit = t[3:0], borrow=0.
  - The borrow register is initialised from the latched bin.
- Result format: if a < b+bin, the output is the ten's complement modulo 10^DIGITS with bout=1. Example: 0003-0005 gives 9998, bout=1.
- Invalid BCD digits (>9) are computed by the same rule and are not saturated; err reports them. err depends only on the latched operands, not on bin.
- diff bits already written are visible while busy. diff is only guaranteed correct when done=1 and afterwards.

Decomposition:
- Shared package bcd_pkg:
  - constant BCD_W=4
  - constant BCD_MAX=9
  - constant BCD_RADIX=10
  - state enum {IDLE, CALC, DONE}
  - function is_bcd_digit
- One combinational sub-module, bcd_digit_sub:
  - inputs a_d[3:0], b_d[3:0], bi
  - outputs d[3:0], bo
  - the single-digit mirror of the BCD adder, and reusable by future multi-digit units.
- The top level holds the FSM, the operand shift/index registers and the output registers.

Test Plan:
- Basic: DIGITS=4, a=1234, b=0567, bin=0, start pulse → busy for 4 cycles, done pulse in cycle 5, diff=0667, bout=0, err=0.
- Negative result: a=0003, b=0005, bin=0 → diff=9998, bout=1, err=0.
- Borrow ripple through zeros: a=1000, b=0001, bin=1 → diff=0998, bout=0. Separately, a=0000, b=0000, bin=1 → diff=9999, bout=1.
- Invalid digit: a=0x00A0, b=0000 → err=1, done still pulses after 4 cycles, diff low digit=0, digit1=0xA (t=10 ≥ 0, passed through).
- Handshake: start re-asserted with new operands during CALC is ignored and the result matches the first operands. start held high in the DONE cycle launches a second operation (9999-0001 → 9998) with no idle cycle.
- Reset mid-op: start, assert rst on the 2nd CALC edge → next cycle busy=0, done=0, diff=0, bout=0, err=0, and no done pulse ever follows.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD constants, FSM state encoding and digit-validity helper.
package bcd_pkg;

  localparam int unsigned BCD_W     = 4;
  localparam int unsigned BCD_MAX   = 9;
  localparam int unsigned BCD_RADIX = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_bcd_digit(input logic [BCD_W-1:0] d);
    return (d <= BCD_W'(BCD_MAX));
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtractor with borrow: d = a_d - b_d - bi, ten's-complement wrap.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a_d,
  input  logic [BCD_W-1:0] b_d,
  input  logic             bi,
  output logic [BCD_W-1:0] d,
  output logic             bo
);

  logic signed [BCD_W+1:0] t;
  logic signed [BCD_W+1:0] t_wrap;

  always_comb begin
    t      = $signed({2'b00, a_d}) - $signed({2'b00, b_d}) - $signed({5'b00000, bi});
    t_wrap = t + $signed((BCD_W+2)'(BCD_RADIX));
    // Out-of-range digits pass through the same rule; no saturation.
    if (t < 0) begin
      d  = BCD_W'(t_wrap);
      bo = 1'b1;
    end else begin
      d  = BCD_W'(t);
      bo = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor, one digit per clock, LSD first, start/busy/done handshake.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BCD_W*DIGITS-1:0] a,
  input  logic [BCD_W*DIGITS-1:0] b,
  input  logic                    bin,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] diff,
  output logic                    bout,
  output logic                    err
);

  localparam int unsigned OP_W  = BCD_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [OP_W-1:0]  a_q,     a_d;
  logic [OP_W-1:0]  b_q,     b_d;
  logic             brw_q,   brw_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [OP_W-1:0]  diff_q,  diff_d;
  logic             bout_q,  bout_d;
  logic             err_q,   err_d;

  logic [BCD_W-1:0] dig_c;
  logic             dig_bo_c;

  // Operand registers shift right, so the active digit is always at the bottom.
  bcd_digit_sub u_digit (
    .a_d (a_q[BCD_W-1:0]),
    .b_d (b_q[BCD_W-1:0]),
    .bi  (brw_q),
    .d   (dig_c),
    .bo  (dig_bo_c)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
    err_d   = err_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          diff_d  = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
          err_d   = 1'b0;
          for (int i = 0; i < int'(DIGITS); i++) begin
            if (!is_bcd_digit(a[i*BCD_W +: BCD_W]) || !is_bcd_digit(b[i*BCD_W +: BCD_W])) begin
              err_d = 1'b1;
            end
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        diff_d[int'(idx_q)*BCD_W +: BCD_W] = dig_c;
        brw_d = dig_bo_c;
        a_d   = a_q >> BCD_W;
        b_d   = b_q >> BCD_W;
        if (idx_q == IDX_W'(DIGITS - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bout_d  = dig_bo_c;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      err_q   <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor: directed cases plus random operands vs. a decimal model.
module tb_bcd_serial_subtractor;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         err;

  int vectors     = 0;
  int miscompares = 0;

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Decimal-value reference for valid operands; digit rule applied literally for invalid ones.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                                output logic [W-1:0] md, output logic mbo, output logic merr);
    longint va = 0, vb = 0, r, modv = 1;
    logic [W-1:0] av, bv;
    logic [3:0] na, nb;
    int t, br;
    av = ma;
    bv = mb;
    merr = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      na = av[i*4 +: 4];
      nb = bv[i*4 +: 4];
      if (na > 4'd9 || nb > 4'd9) merr = 1'b1;
      va = va * 10 + longint'(na);
      vb = vb * 10 + longint'(nb);
      modv = modv * 10;
    end
    md = '0;
    if (!merr) begin
      r   = va - vb - longint'(mbin);
      mbo = (r < 0);
      if (r < 0) r = r + modv;
      for (int i = 0; i < DIGITS; i++) begin
        md[i*4 +: 4] = 4'(r % 10);
        r = r / 10;
      end
    end else begin
      br = int'(mbin);
      for (int i = 0; i < DIGITS; i++) begin
        t = int'(av[i*4 +: 4]) - int'(bv[i*4 +: 4]) - br;
        if (t < 0) begin
          t  = t + 10;
          br = 1;
        end else begin
          br = 0;
        end
        md[i*4 +: 4] = 4'(t);
      end
      mbo = (br != 0);
    end
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[i*4 +: 4] = 4'($urandom_range(9, 0));
    return v;
  endfunction

  // Launch one operation, scramble inputs afterwards, and check latency and result.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
    logic [W-1:0] ed;
    logic eb, ee;
    int busy_cnt, n;
    model(ta, tb_, tbin, ed, eb, ee);
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    busy_cnt = 0;
    n = 0;
    while (!done && n < 50) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    check({tag, ".done"}, 64'(done), 64'(1));
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(DIGITS));
    check({tag, ".diff"}, 64'(diff), 64'(ed));
    check({tag, ".bout"}, 64'(bout), 64'(eb));
    check({tag, ".err"}, 64'(err), 64'(ee));
    @(negedge clk);
    check({tag, ".done_1cyc"}, 64'(done), 64'(0));
    check({tag, ".diff_hold"}, 64'(diff), 64'(ed));
  endtask

  initial begin
    logic [W-1:0] ed, ra, rb;
    logic eb, ee;
    int n;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.busy", 64'(busy), 64'(0));
    check("reset.done", 64'(done), 64'(0));
    check("reset.diff", 64'(diff), 64'(0));
    check("reset.bout", 64'(bout), 64'(0));
    check("reset.err",  64'(err),  64'(0));
    rst = 1'b0;

    run_op("basic",    16'h1234, 16'h0567, 1'b0);
    check("basic.const", 64'(diff), 64'h0667);
    run_op("negative", 16'h0003, 16'h0005, 1'b0);
    check("negative.const", 64'(diff), 64'h9998);
    run_op("ripple",   16'h1000, 16'h0001, 1'b1);
    check("ripple.const", 64'(diff), 64'h0998);
    run_op("allborrow", 16'h0000, 16'h0000, 1'b1);
    check("allborrow.const", 64'({bout, diff}), 64'h19999);
    run_op("invalid",  16'h00A0, 16'h0000, 1'b0);
    check("invalid.const", 64'({err, diff}), 64'h100A0);

    // Start during CALC must be ignored.
    model(16'h4321, 16'h1111, 1'b0, ed, eb, ee);
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 16'h0005; b = 16'h0009; bin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 50) begin @(negedge clk); n++; end
    check("ignore.done", 64'(done), 64'(1));
    check("ignore.diff", 64'(diff), 64'(ed));
    check("ignore.bout", 64'(bout), 64'(eb));

    // Start held in the DONE cycle launches back-to-back.
    a = 16'h9999; b = 16'h0001; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b.busy_now", 64'(busy), 64'(1));
    n = 0;
    while (!done && n < 50) begin @(negedge clk); n++; end
    check("b2b.done", 64'(done), 64'(1));
    check("b2b.diff", 64'(diff), 64'h9998);
    check("b2b.bout", 64'(bout), 64'(0));
    @(negedge clk);

    // Reset on the 2nd CALC edge aborts cleanly.
    a = 16'h5555; b = 16'h1234; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid.busy", 64'(busy), 64'(0));
    check("rstmid.done", 64'(done), 64'(0));
    check("rstmid.diff", 64'(diff), 64'(0));
    check("rstmid.bout", 64'(bout), 64'(0));
    check("rstmid.err",  64'(err),  64'(0));
    n = 0;
    for (int i = 0; i < DIGITS + 4; i++) begin
      if (done || busy) n++;
      @(negedge clk);
    end
    check("rstmid.no_done", 64'(n), 64'(0));

    for (int k = 0; k < 30; k++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      run_op("rand_bcd", ra, rb, 1'($urandom));
    end
    for (int k = 0; k < 10; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op("rand_raw", ra, rb, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
